rsp_drain_sched: RTL and testbench

- Read-side scheduler for the per-tag reorder buffer in the DMA read path.
- Records DMA read tags in issue order and drains each tag's stored response sub-packets from the buffer's fetch channel strictly in that order.
- Sends them downstream on a valid/ready stream and returns each tag to the tag allocator after its last beat leaves.
- Sits between the reorder buffer fetch channel and the DMA read response output.

---
 rtl/rsp_drain_sched_if.sv | 45 ++++
 rtl/rsp_drain_sched.sv | 200 ++++++++++++++++++++
 tb/tb_rsp_drain_sched.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rsp_drain_sched_if.sv
// Bundle of the order, fetch, response and free channels around the
// reorder-buffer drain scheduler. master = scheduler side, slave = environment.
interface rsp_drain_sched_if #(
    parameter int TAG_W  = 6,
    parameter int DATA_W = 256
);
    logic              ord_vld;
    logic [TAG_W-1:0]  ord_tag;
    logic              ord_rdy;

    logic              fetch_ren;
    logic [TAG_W-1:0]  fetch_tag;
    logic              fetch_last;
    logic [DATA_W-1:0] fetch_data;
    logic              fetch_vld;

    logic              rsp_vld;
    logic              rsp_last;
    logic [TAG_W-1:0]  rsp_tag;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_rdy;

    logic              free_vld;
    logic [TAG_W-1:0]  free_tag;

    modport master (
        input  ord_vld, ord_tag,
        output ord_rdy,
        output fetch_ren, fetch_tag,
        input  fetch_last, fetch_data, fetch_vld,
        output rsp_vld, rsp_last, rsp_tag, rsp_data,
        input  rsp_rdy,
        output free_vld, free_tag
    );

    modport slave (
        output ord_vld, ord_tag,
        input  ord_rdy,
        input  fetch_ren, fetch_tag,
        output fetch_last, fetch_data, fetch_vld,
        input  rsp_vld, rsp_last, rsp_tag, rsp_data,
        output rsp_rdy,
        input  free_vld, free_tag
    );
endinterface

// File: rtl/rsp_drain_sched.sv
// Drains per-tag reorder-buffer contents in DMA issue order onto a valid/ready
// response stream and releases each tag once its last beat is captured.
module rsp_drain_sched #(
    parameter int TAG_W  = 6,
    parameter int DATA_W = 256
) (
    input  logic                 dma_clk,
    input  logic                 rst_n,
    rsp_drain_sched_if.master    bus
);
    localparam int DEPTH = 1 << TAG_W;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;

    logic [TAG_W-1:0]   ord_mem_r [DEPTH];
    logic [TAG_W:0]     ord_wr_ptr_r;
    logic [TAG_W:0]     ord_rd_ptr_r;
    logic               ord_full_s;
    logic               ord_empty_s;
    logic               ord_push_s;
    logic               ord_pop_s;
    logic [TAG_W-1:0]   ord_head_s;

    logic [TAG_W-1:0]   cur_tag_r;
    logic               rd_pend_r;
    logic               stale_r;
    logic               last_seen_r;
    logic               free_vld_r;
    logic [TAG_W-1:0]   free_tag_r;

    logic               fetch_ren_s;
    logic               cap_s;
    logic               cap_last_s;
    logic               credit_ok_s;

    logic               head_vld_r;
    logic               head_last_r;
    logic [TAG_W-1:0]   head_tag_r;
    logic [DATA_W-1:0]  head_data_r;
    logic               tail_vld_r;
    logic               tail_last_r;
    logic [TAG_W-1:0]   tail_tag_r;
    logic [DATA_W-1:0]  tail_data_r;
    logic               rsp_pop_s;
    logic               head_free_s;
    logic [1:0]         obuf_cnt_s;
    logic [1:0]         obuf_net_s;
    logic [1:0]         credit_sum_s;

    assign ord_full_s  = (ord_wr_ptr_r[TAG_W] != ord_rd_ptr_r[TAG_W]) &&
                         (ord_wr_ptr_r[TAG_W-1:0] == ord_rd_ptr_r[TAG_W-1:0]);
    assign ord_empty_s = (ord_wr_ptr_r == ord_rd_ptr_r);
    assign ord_push_s  = bus.ord_vld & ~ord_full_s;
    assign ord_head_s  = ord_mem_r[ord_rd_ptr_r[TAG_W-1:0]];

    // A returned beat counts only if it answers a live fetch of the current tag.
    assign cap_s       = rd_pend_r & bus.fetch_vld & ~stale_r;
    assign cap_last_s  = cap_s & bus.fetch_last;

    // Occupancy is taken net of the beat leaving this cycle so that a
    // continuously ready sink sees one beat per cycle.
    assign rsp_pop_s    = head_vld_r & bus.rsp_rdy;
    assign head_free_s  = ~head_vld_r | rsp_pop_s;
    assign obuf_cnt_s   = {1'b0, head_vld_r} + {1'b0, tail_vld_r};
    assign obuf_net_s   = obuf_cnt_s - {1'b0, rsp_pop_s};
    assign credit_sum_s = obuf_net_s + {1'b0, rd_pend_r};
    assign credit_ok_s  = (credit_sum_s < 2'd2);

    // Next-state and fetch request decode.
    always_comb begin
        state_nxt_s = state_r;
        ord_pop_s   = 1'b0;
        fetch_ren_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!ord_empty_s) begin
                    ord_pop_s   = 1'b1;
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (credit_ok_s && !last_seen_r) begin
                    fetch_ren_s = 1'b1;
                end else begin
                    fetch_ren_s = 1'b0;
                end
                if (cap_last_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Order FIFO storage; validity is carried entirely by the pointers.
    always_ff @(posedge dma_clk) begin
        if (ord_push_s) begin
            ord_mem_r[ord_wr_ptr_r[TAG_W-1:0]] <= bus.ord_tag;
        end
    end

    // FSM, order pointers, fetch bookkeeping and tag release.
    always_ff @(posedge dma_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            ord_wr_ptr_r <= '0;
            ord_rd_ptr_r <= '0;
            cur_tag_r    <= '0;
            rd_pend_r    <= 1'b0;
            stale_r      <= 1'b0;
            last_seen_r  <= 1'b0;
            free_vld_r   <= 1'b0;
            free_tag_r   <= '0;
        end else begin
            state_r   <= state_nxt_s;
            rd_pend_r <= fetch_ren_s;
            // A fetch launched alongside the last capture belongs to no beat.
            stale_r   <= fetch_ren_s & cap_last_s;
            if (ord_push_s) begin
                ord_wr_ptr_r <= ord_wr_ptr_r + (TAG_W+1)'(1);
            end
            if (ord_pop_s) begin
                ord_rd_ptr_r <= ord_rd_ptr_r + (TAG_W+1)'(1);
                cur_tag_r    <= ord_head_s;
            end
            if (cap_last_s) begin
                last_seen_r <= 1'b1;
            end else if (ord_pop_s) begin
                last_seen_r <= 1'b0;
            end
            free_vld_r <= cap_last_s;
            if (cap_last_s) begin
                free_tag_r <= cur_tag_r;
            end
        end
    end

    // Two-entry output buffer: head drives the response port, tail is the skid slot.
    always_ff @(posedge dma_clk or negedge rst_n) begin
        if (!rst_n) begin
            head_vld_r  <= 1'b0;
            head_last_r <= 1'b0;
            head_tag_r  <= '0;
            head_data_r <= '0;
            tail_vld_r  <= 1'b0;
            tail_last_r <= 1'b0;
            tail_tag_r  <= '0;
            tail_data_r <= '0;
        end else if (head_free_s) begin
            if (tail_vld_r) begin
                head_vld_r  <= 1'b1;
                head_last_r <= tail_last_r;
                head_tag_r  <= tail_tag_r;
                head_data_r <= tail_data_r;
                tail_vld_r  <= cap_s;
                if (cap_s) begin
                    tail_last_r <= bus.fetch_last;
                    tail_tag_r  <= cur_tag_r;
                    tail_data_r <= bus.fetch_data;
                end
            end else begin
                head_vld_r <= cap_s;
                tail_vld_r <= 1'b0;
                if (cap_s) begin
                    head_last_r <= bus.fetch_last;
                    head_tag_r  <= cur_tag_r;
                    head_data_r <= bus.fetch_data;
                end
            end
        end else if (cap_s) begin
            tail_vld_r  <= 1'b1;
            tail_last_r <= bus.fetch_last;
            tail_tag_r  <= cur_tag_r;
            tail_data_r <= bus.fetch_data;
        end
    end

    assign bus.ord_rdy   = ~ord_full_s;
    assign bus.fetch_ren = fetch_ren_s;
    assign bus.fetch_tag = cur_tag_r;
    assign bus.rsp_vld   = head_vld_r;
    assign bus.rsp_last  = head_last_r;
    assign bus.rsp_tag   = head_tag_r;
    assign bus.rsp_data  = head_data_r;
    assign bus.free_vld  = free_vld_r;
    assign bus.free_tag  = free_tag_r;

endmodule

// File: tb/tb_rsp_drain_sched.sv
// Self-checking bench: reorder-buffer responder, stream/free scoreboard,
// table-driven single-tag cases, hand-written corner sequences, random phase.
module tb_rsp_drain_sched;
    localparam int TAG_W  = 6;
    localparam int DATA_W = 256;
    localparam int NTAG   = 64;
    localparam int SDEP   = 32;

    logic dma_clk = 1'b0;
    logic rst_n   = 1'b0;
    always #5 dma_clk = ~dma_clk;

    rsp_drain_sched_if #(.TAG_W(TAG_W), .DATA_W(DATA_W)) bus ();

    rsp_drain_sched #(.TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
        .dma_clk (dma_clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    typedef struct {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    typedef struct {
        int tag;
        int nbeats;
        int gap;        // 0: all beats stored up front, else one released every gap cycles
        int rdy_low;    // cycles rsp_rdy held low at the start
        int exp_beats;
        int exp_span;   // expected cycles from first to last beat, -1 = unchecked
    } vec_t;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reorder-buffer model: per-tag ring of stored beats, avail = readable now.
    logic [DATA_W-1:0] sdata [NTAG][SDEP];
    logic              slast [NTAG][SDEP];
    int swr [NTAG];
    int srd [NTAG];
    int avail [NTAG];
    int hidden [NTAG];

    beat_t            exp_q[$];
    logic [TAG_W-1:0] free_q[$];

    int   occ       = 0;
    int   pend_prev = 0;
    logic last_prev = 1'b0;
    int   case_cnt  = 0;
    int   case_first = 0;
    int   case_last  = 0;

    always @(posedge dma_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge dma_clk);
        #1;
    endtask

    task automatic clear_model();
        for (int t = 0; t < NTAG; t++) begin
            swr[t] = 0; srd[t] = 0; avail[t] = 0; hidden[t] = 0;
        end
        exp_q.delete();
        free_q.delete();
        occ = 0; pend_prev = 0; last_prev = 1'b0;
    endtask

    // Buffer responder: answers a fetch one cycle later, empty tag -> fetch_vld=0.
    initial begin
        logic              r_vld;
        logic              r_last;
        logic [DATA_W-1:0] r_data;
        int                t;
        bus.fetch_vld  = 1'b0;
        bus.fetch_last = 1'b0;
        bus.fetch_data = '0;
        forever begin
            @(negedge dma_clk);
            r_vld = 1'b0; r_last = 1'b0; r_data = '0;
            if (rst_n && bus.fetch_ren) begin
                t = int'(bus.fetch_tag);
                if (avail[t] > 0) begin
                    r_vld  = 1'b1;
                    r_data = sdata[t][srd[t] % SDEP];
                    r_last = slast[t][srd[t] % SDEP];
                    srd[t]++;
                    avail[t]--;
                end
            end
            @(posedge dma_clk);
            #1;
            bus.fetch_vld  = r_vld;
            bus.fetch_last = r_last;
            bus.fetch_data = r_data;
        end
    end

    // Monitor: credit bound, response validity, free timing and stream order.
    initial begin
        beat_t            e;
        logic [TAG_W-1:0] ft;
        forever begin
            @(negedge dma_clk);
            if (rst_n) begin
                checks++;
                if (occ + pend_prev > 2) begin
                    errors++;
                    $display("FAIL credit: buffered %0d + pending %0d, required <= 2", occ, pend_prev);
                end
                checks++;
                if (bus.rsp_vld !== (occ > 0)) begin
                    errors++;
                    $display("FAIL rsp_vld: got %0b with %0d beats buffered", bus.rsp_vld, occ);
                end
                checks++;
                if (bus.free_vld !== last_prev) begin
                    errors++;
                    $display("FAIL free_timing: free_vld %0b, required %0b", bus.free_vld, last_prev);
                end
                if (bus.rsp_vld && bus.rsp_rdy) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL beat: unexpected beat tag %0d", bus.rsp_tag);
                    end else begin
                        e = exp_q.pop_front();
                        if (bus.rsp_tag !== e.tag || bus.rsp_data !== e.data || bus.rsp_last !== e.last) begin
                            errors++;
                            $display("FAIL beat: got tag %0d last %0b data %h, required tag %0d last %0b data %h",
                                     bus.rsp_tag, bus.rsp_last, bus.rsp_data, e.tag, e.last, e.data);
                        end
                    end
                    case_cnt++;
                    if (case_cnt == 1) case_first = cyc;
                    case_last = cyc;
                end
                if (bus.free_vld) begin
                    checks++;
                    if (free_q.size() == 0) begin
                        errors++;
                        $display("FAIL free: unexpected free of tag %0d", bus.free_tag);
                    end else begin
                        ft = free_q.pop_front();
                        if (bus.free_tag !== ft) begin
                            errors++;
                            $display("FAIL free: got tag %0d, required %0d", bus.free_tag, ft);
                        end
                    end
                end
                occ = occ + (bus.fetch_vld ? 1 : 0) - ((bus.rsp_vld && bus.rsp_rdy) ? 1 : 0);
                pend_prev = bus.fetch_ren ? 1 : 0;
                last_prev = bus.fetch_vld & bus.fetch_last;
            end
        end
    end

    task automatic add_beats(input int tag, input int n, input bit vis);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.tag  = TAG_W'(tag);
            b.data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            b.last = (i == n - 1);
            sdata[tag][swr[tag] % SDEP] = b.data;
            slast[tag][swr[tag] % SDEP] = b.last;
            swr[tag]++;
            exp_q.push_back(b);
        end
        free_q.push_back(TAG_W'(tag));
        if (vis) avail[tag] += n;
        else     hidden[tag] += n;
    endtask

    task automatic do_ord(input int tag);
        int n = 0;
        while (!bus.ord_rdy && n < 200) begin
            step();
            n++;
        end
        chk("ord_rdy_wait", int'(bus.ord_rdy), 1);
        bus.ord_vld = 1'b1;
        bus.ord_tag = TAG_W'(tag);
        step();
        bus.ord_vld = 1'b0;
    endtask

    task automatic issue(input int tag, input int n, input bit vis);
        add_beats(tag, n, vis);
        do_ord(tag);
    endtask

    task automatic release_one(input int tag);
        if (hidden[tag] > 0) begin
            hidden[tag]--;
            avail[tag]++;
        end
    endtask

    task automatic wait_drain(input string name, input int maxc);
        int n = 0;
        while ((exp_q.size() != 0 || free_q.size() != 0) && n < maxc) begin
            step();
            n++;
        end
        chk(name, exp_q.size() + free_q.size(), 0);
    endtask

    task automatic check_reset(input string name);
        chk({name, "_fetch_ren"}, int'(bus.fetch_ren), 0);
        chk({name, "_fetch_tag"}, int'(bus.fetch_tag), 0);
        chk({name, "_rsp_vld"},   int'(bus.rsp_vld), 0);
        chk({name, "_rsp_last"},  int'(bus.rsp_last), 0);
        chk({name, "_rsp_tag"},   int'(bus.rsp_tag), 0);
        chk({name, "_rsp_data"},  int'(bus.rsp_data != '0), 0);
        chk({name, "_free_vld"},  int'(bus.free_vld), 0);
        chk({name, "_free_tag"},  int'(bus.free_tag), 0);
        chk({name, "_ord_rdy"},   int'(bus.ord_rdy), 1);
    endtask

    task automatic do_reset(input string name);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset(name);
        bus.ord_vld = 1'b0;
        clear_model();
        step();
        step();
        rst_n = 1'b1;
        chk({name, "_ord_rdy_after"}, int'(bus.ord_rdy), 1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk({name, "_idle_fetch"}, int'(bus.fetch_ren), 0);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[3];
        int   k;
        int   tg;

        vecs[0] = '{tag: 7, nbeats: 8, gap: 0, rdy_low: 0,  exp_beats: 8, exp_span: 7};
        vecs[1] = '{tag: 3, nbeats: 4, gap: 0, rdy_low: 10, exp_beats: 4, exp_span: -1};
        vecs[2] = '{tag: 1, nbeats: 3, gap: 5, rdy_low: 0,  exp_beats: 3, exp_span: -1};

        bus.ord_vld = 1'b0;
        bus.ord_tag = '0;
        bus.rsp_rdy = 1'b0;
        clear_model();

        repeat (3) @(posedge dma_clk);
        #1;
        check_reset("reset");
        rst_n = 1'b1;
        step();

        // Tags 5 then 2: tag 2 is ready first but must wait behind tag 5.
        bus.rsp_rdy = 1'b1;
        issue(5, 3, 1'b0);
        issue(2, 2, 1'b1);
        repeat (20) step();
        for (int i = 0; i < 3; i++) release_one(5);
        wait_drain("order_5_2", 200);

        for (int v = 0; v < 3; v++) begin
            case_cnt = 0;
            bus.rsp_rdy = (vecs[v].rdy_low == 0);
            issue(vecs[v].tag, vecs[v].nbeats, vecs[v].gap == 0);
            k = 0;
            while ((exp_q.size() != 0 || free_q.size() != 0 || k < vecs[v].rdy_low) && k < 300) begin
                step();
                k++;
                if (k == vecs[v].rdy_low) bus.rsp_rdy = 1'b1;
                if (vecs[v].gap > 0 && (k % vecs[v].gap) == vecs[v].gap - 1) release_one(vecs[v].tag);
            end
            chk($sformatf("vec%0d_drained", v), exp_q.size() + free_q.size(), 0);
            chk($sformatf("vec%0d_beats", v), case_cnt, vecs[v].exp_beats);
            if (vecs[v].exp_span >= 0)
                chk($sformatf("vec%0d_span", v), case_last - case_first, vecs[v].exp_span);
        end

        // Fill the order FIFO: the first tag is popped into the drain slot,
        // so 64 further tags fill it.
        bus.rsp_rdy = 1'b1;
        for (int i = 0; i < 65; i++) begin
            do_ord(i % NTAG);
            if (i == 63) chk("fill_rdy_63", int'(bus.ord_rdy), 1);
        end
        chk("fill_full", int'(bus.ord_rdy), 0);
        add_beats(0, 1, 1'b1);
        wait_drain("fill_free", 100);
        step();
        step();
        chk("fill_one_slot", int'(bus.ord_rdy), 1);
        do_ord(9);
        chk("fill_full_again", int'(bus.ord_rdy), 0);
        do_reset("fill_rst");

        // Reset mid-drain of tag 9 with one beat buffered.
        bus.rsp_rdy = 1'b0;
        issue(9, 3, 1'b0);
        release_one(9);
        k = 0;
        while (!bus.rsp_vld && k < 20) begin
            step();
            k++;
        end
        chk("t9_buffered", int'(bus.rsp_vld), 1);
        repeat (3) step();
        do_reset("mid_rst");

        // Random phase: distinct tags per round, random readiness and arrival.
        for (int r = 0; r < 4; r++) begin
            bus.rsp_rdy = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 8; i++) begin
                tg = (r * 13 + i * 7 + 1) % NTAG;
                issue(tg, $urandom_range(1, 4), $urandom_range(0, 1) == 1);
            end
            k = 0;
            while ((exp_q.size() != 0 || free_q.size() != 0) && k < 2000) begin
                step();
                k++;
                bus.rsp_rdy = ($urandom_range(0, 3) != 0);
                for (int t = 0; t < NTAG; t++)
                    if (hidden[t] > 0 && $urandom_range(0, 2) == 0) release_one(t);
            end
            chk($sformatf("rand%0d_drained", r), exp_q.size() + free_q.size(), 0);
        end

        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
